clock_time_ctrl: RTL and testbench
==================================

Name: clock_time_ctrl

Overview:
- Mode/sequencing controller for the wall-clock datapath: drives the up/down strobes of the seconds (0-59), minutes (0-59) and hours (0-23) wrap counters.
- RUN mode: ripples the 1 Hz tick through the counter chain using the counters' carry outputs.
- Set modes: converts push-button edges into single up/down steps on the selected field, with the clock paused.
- Sits between the button synchronizers and the counter bank; also drives the display blink and mode indication.

Parameters:
- TIMEOUT_TICKS, 30: i_tick pulses with no button activity in a set state before automatic return to RUN.
- REPEAT_DELAY, 8: clock cycles a button must stay held after its edge before auto-repeat starts (AUTOREPEAT_EN only).
- REPEAT_PERIOD, 4: clock cycles between auto-repeat steps (AUTOREPEAT_EN only).

Ports:
- i_clk  input  1  system clock
- i_rstn  input  1  asynchronous active-low reset
- i_tick  input  1  1 Hz enable pulse, one cycle wide
- i_mode_btn  input  1  synchronized mode button level
- i_up_btn  input  1  synchronized up button level
- i_down_btn  input  1  synchronized down button level
- i_sec_carry  input  1  seconds counter carry-up (combinational from counter)
- i_min_carry  input  1  minutes counter carry-up
- o_sec_up, o_sec_down  output  1 each  seconds counter strobes
- o_min_up, o_min_down  output  1 each  minutes counter strobes
- o_hour_up, o_hour_down  output  1 each  hours counter strobes
- o_state  output  2  00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC
- o_blink  output  1  display enable for the selected field

Behaviour:
- Reset (async, i_rstn=0):
  - state=RUN, o_blink=1, all strobes 0.
  - Button-history registers cleared to 0; timeout counter 0.
  - Reset mid-set returns to RUN immediately; the counters keep their own values.
- Edge detect: a button edge occurs in a cycle where the level is 1 and the registered previous level is 0. A level already high at reset release counts as an edge.
- FSM, advanced on mode edges: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
  - On entry to any set state: timeout counter cleared, o_blink=1.
- RUN strobes (combinational, same cycle):
  - o_sec_up = i_tick
  - o_min_up = i_sec_carry
  - o_hour_up = i_min_carry
  - All down strobes 0. Button up/down edges are ignored.
- Set states:
  - i_tick does not step any counter, and carries are not forwarded.
  - An up or down edge produces a one-cycle registered strobe on the selected field only, in the cycle after the edge.
  - Counter wrap is handled by the counters: hours 23 -> 0 on up, 0 -> 23 on down.
- Simultaneous events:
  - Up and down edges in the same cycle: both dropped, no strobe. A 2'b11 strobe pair, which would clear the counter, is never issued.
  - Mode edge together with an up/down edge: the mode transition is taken and the step is dropped.
- Timeout (set states only):
  - Counter increments on each i_tick and clears on any button edge.
  - On reaching TIMEOUT_TICKS: state -> RUN next cycle.
- Blink:
  - 1 constantly in RUN.
  - In set states it toggles on each i_tick and is forced to 1 on any step strobe.
- Strobes are never asserted in the same cycle as a state change.

Optional Feature:
- Macro: AUTOREPEAT_EN.
- Defined:
  - In a set state, if the up or down level stays 1 for REPEAT_DELAY cycles after its edge, a strobe is issued, then another every REPEAT_PERIOD cycles while held.
  - Releasing the button, a mode edge, a state change or reset cancels the repeat.
  - Both buttons held together: no repeat.
  - Each repeat strobe clears the timeout counter.
- Undefined: exactly one step per edge. The repeat counters and REPEAT_* parameters are unused and no logic is generated.

Test Plan:
- Reset, then RUN with counter chain 00:59:59 and one i_tick -> o_sec_up, o_min_up and o_hour_up all 1 in the same cycle; chain reads 01:00:00.
- One mode edge, then 3 up edges -> o_state=01 and exactly 3 o_hour_up pulses, each one cycle after its edge; hour 0 -> 3; no sec/min strobes; i_tick pulses produce no strobes.
- In SET_HOUR with hour=0, one down edge -> single o_hour_down pulse; hour reads 23.
- Up and down edges in the same cycle in SET_MIN -> no strobe; mode and up edges together -> o_state 10 -> 11, no o_min_up.
- Enter SET_SEC, 30 ticks with no buttons -> o_state=00 after the 30th tick; o_blink toggled 29 times in between and is 1 in RUN.
- With AUTOREPEAT_EN, up held 20 cycles in SET_MIN -> strobes at edge+1, then at cycles 8, 12, 16, 20 after the edge; drop i_rstn mid-hold -> o_state=00, strobes 0 immediately.

Source files
------------

// File: rtl/clock_time_ctrl.sv
// Mode/sequencing controller for the wall-clock counter bank (RUN, SET_HOUR, SET_MIN, SET_SEC).
// Optional held-button auto-repeat is built only when AUTOREPEAT_EN is defined.
module clock_time_ctrl #(
`ifdef AUTOREPEAT_EN
   parameter int REPEAT_DELAY  = 8,
   parameter int REPEAT_PERIOD = 4,
`endif
   parameter int TIMEOUT_TICKS = 30
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic       i_tick,
   input  logic       i_mode_btn,
   input  logic       i_up_btn,
   input  logic       i_down_btn,
   input  logic       i_sec_carry,
   input  logic       i_min_carry,
   output logic       o_sec_up,
   output logic       o_sec_down,
   output logic       o_min_up,
   output logic       o_min_down,
   output logic       o_hour_up,
   output logic       o_hour_down,
   output logic [1:0] o_state,
   output logic       o_blink
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      SET_HOUR = 2'b01,
      SET_MIN  = 2'b10,
      SET_SEC  = 2'b11
   } state_e;

   localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

   state_e          state_q, state_d;
   logic            modePrev_q, upPrev_q, downPrev_q;
   logic [TO_W-1:0] toCnt_q, toCnt_d;
   logic            blink_q, blink_d;
   logic            stepUp_q, stepUp_d;
   logic            stepDown_q, stepDown_d;
   logic            modeEdge, upEdge, downEdge, oneEdge, inSet;
   logic            rptFire, rptDir;

   assign modeEdge = i_mode_btn & ~modePrev_q;
   assign upEdge   = i_up_btn & ~upPrev_q;
   assign downEdge = i_down_btn & ~downPrev_q;
   assign oneEdge  = upEdge ^ downEdge;
   assign inSet    = (state_q != RUN);

`ifdef AUTOREPEAT_EN
   localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
   localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

   logic             rptActive_q, rptActive_d;
   logic             rptDir_q, rptDir_d;
   logic [RPT_W-1:0] rptCnt_q, rptCnt_d;
   logic             rptHeld;

   assign rptHeld = rptDir_q ? (i_up_btn & ~i_down_btn) : (i_down_btn & ~i_up_btn);
   assign rptDir  = rptDir_q;

   // Counter holds cycles since the edge; after the first repeat it reloads so later ones are a period apart.
   always_comb begin
      rptActive_d = rptActive_q;
      rptDir_d    = rptDir_q;
      rptCnt_d    = rptCnt_q;
      rptFire     = 1'b0;
      if (!inSet || modeEdge) begin
         rptActive_d = 1'b0;
      end else if (oneEdge) begin
         rptActive_d = 1'b1;
         rptDir_d    = upEdge;
         rptCnt_d    = RPT_W'(1);
      end else if (upEdge && downEdge) begin
         rptActive_d = 1'b0;
      end else if (rptActive_q) begin
         if (!rptHeld) begin
            rptActive_d = 1'b0;
         end else if (rptCnt_q == RPT_LAST) begin
            rptFire  = 1'b1;
            rptCnt_d = RPT_RELOAD;
         end else begin
            rptCnt_d = rptCnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         rptActive_q <= 1'b0;
         rptDir_q    <= 1'b0;
         rptCnt_q    <= '0;
      end else begin
         rptActive_q <= rptActive_d;
         rptDir_q    <= rptDir_d;
         rptCnt_q    <= rptCnt_d;
      end
   end
`else
   assign rptFire = 1'b0;
   assign rptDir  = 1'b0;
`endif

   // Mode edges win over steps; a same-cycle up+down pair is dropped so 2'b11 is never issued.
   always_comb begin
      state_d    = state_q;
      toCnt_d    = toCnt_q;
      blink_d    = blink_q;
      stepUp_d   = 1'b0;
      stepDown_d = 1'b0;
      if (!inSet) begin
         toCnt_d = '0;
         blink_d = 1'b1;
         if (modeEdge) state_d = SET_HOUR;
      end else if (modeEdge) begin
         toCnt_d = '0;
         blink_d = 1'b1;
         case (state_q)
            SET_HOUR: state_d = SET_MIN;
            SET_MIN:  state_d = SET_SEC;
            default:  state_d = RUN;
         endcase
      end else begin
         if (i_tick) blink_d = ~blink_q;
         if (upEdge || downEdge || rptFire) begin
            toCnt_d = '0;
         end else if (i_tick) begin
            if (toCnt_q == TO_LAST) begin
               state_d = RUN;
               toCnt_d = '0;
               blink_d = 1'b1;
            end else begin
               toCnt_d = toCnt_q + 1'b1;
            end
         end
         if (oneEdge) begin
            stepUp_d   = upEdge;
            stepDown_d = downEdge;
            blink_d    = 1'b1;
         end else if (rptFire) begin
            stepUp_d   = rptDir;
            stepDown_d = ~rptDir;
            blink_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q    <= RUN;
         modePrev_q <= 1'b0;
         upPrev_q   <= 1'b0;
         downPrev_q <= 1'b0;
         toCnt_q    <= '0;
         blink_q    <= 1'b1;
         stepUp_q   <= 1'b0;
         stepDown_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         modePrev_q <= i_mode_btn;
         upPrev_q   <= i_up_btn;
         downPrev_q <= i_down_btn;
         toCnt_q    <= toCnt_d;
         blink_q    <= blink_d;
         stepUp_q   <= stepUp_d;
         stepDown_q <= stepDown_d;
      end
   end

   // RUN ripples the tick through the carry chain combinationally; set states use the registered steps.
   always_comb begin
      o_sec_up    = 1'b0;
      o_sec_down  = 1'b0;
      o_min_up    = 1'b0;
      o_min_down  = 1'b0;
      o_hour_up   = 1'b0;
      o_hour_down = 1'b0;
      case (state_q)
         RUN: begin
            o_sec_up  = i_tick;
            o_min_up  = i_sec_carry;
            o_hour_up = i_min_carry;
         end
         SET_HOUR: begin
            o_hour_up   = stepUp_q;
            o_hour_down = stepDown_q;
         end
         SET_MIN: begin
            o_min_up   = stepUp_q;
            o_min_down = stepDown_q;
         end
         default: begin
            o_sec_up   = stepUp_q;
            o_sec_down = stepDown_q;
         end
      endcase
   end

   assign o_state = state_q;
   assign o_blink = (state_q == RUN) | blink_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl with a behavioural seconds/minutes/hours counter bank.
// Expectations for held buttons follow whether AUTOREPEAT_EN is defined.
module tb_clock_time_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstn, tick, modeBtn, upBtn, downBtn;
   logic       secCarry, minCarry;
   logic       secUp, secDown, minUp, minDown, hourUp, hourDown;
   logic [1:0] state;
   logic       blink;

   logic [5:0] sec, min, hour;
   logic       presetEn;
   logic [5:0] presetSec, presetMin, presetHour;
   int         hourUpCount = 0;
   int         otherCount  = 0;
   int         pairCount   = 0;

   int checkCount = 0;
   int failCount  = 0;

   clock_time_ctrl dut (
      .i_clk       (clk),
      .i_rstn      (rstn),
      .i_tick      (tick),
      .i_mode_btn  (modeBtn),
      .i_up_btn    (upBtn),
      .i_down_btn  (downBtn),
      .i_sec_carry (secCarry),
      .i_min_carry (minCarry),
      .o_sec_up    (secUp),
      .o_sec_down  (secDown),
      .o_min_up    (minUp),
      .o_min_down  (minDown),
      .o_hour_up   (hourUp),
      .o_hour_down (hourDown),
      .o_state     (state),
      .o_blink     (blink)
   );

   assign secCarry = secUp & ~secDown & (sec == 6'd59);
   assign minCarry = minUp & ~minDown & (min == 6'd59);

   function automatic logic [5:0] stepVal(input logic [5:0] v, input logic up, input logic dn,
                                          input logic [5:0] maxV);
      case ({up, dn})
         2'b10:   return (v == maxV) ? 6'd0 : v + 6'd1;
         2'b01:   return (v == 6'd0) ? maxV : v - 6'd1;
         2'b11:   return 6'd0;
         default: return v;
      endcase
   endfunction

   // Stand-in for the wrap counters the controller drives.
   always @(posedge clk) begin
      if (presetEn) begin
         sec  <= presetSec;
         min  <= presetMin;
         hour <= presetHour;
      end else begin
         sec  <= stepVal(sec, secUp, secDown, 6'd59);
         min  <= stepVal(min, minUp, minDown, 6'd59);
         hour <= stepVal(hour, hourUp, hourDown, 6'd23);
      end
      if (hourUp) hourUpCount <= hourUpCount + 1;
      if (secUp | secDown | minUp | minDown) otherCount <= otherCount + 1;
      if ((secUp & secDown) | (minUp & minDown) | (hourUp & hourDown)) pairCount <= pairCount + 1;
   end

   function automatic logic [5:0] strobes();
      return {secUp, secDown, minUp, minDown, hourUp, hourDown};
   endfunction

   task automatic applyStimulus(input logic m, input logic u, input logic d, input logic t);
      @(negedge clk);
      modeBtn = m;
      upBtn   = u;
      downBtn = d;
      tick    = t;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   initial begin
      int hourBase, otherBase, toggles;
      logic prevBlink, expStrobe;
      rstn = 1'b0; tick = 1'b0; modeBtn = 1'b0; upBtn = 1'b0; downBtn = 1'b0;
      presetEn = 1'b1; presetSec = 6'd59; presetMin = 6'd59; presetHour = 6'd0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_state", 32'(state), 32'd0);
      checkOutput("reset_blink", 32'(blink), 32'd1);
      checkOutput("reset_strobes", 32'(strobes()), 32'd0);
      rstn = 1'b1;
      presetEn = 1'b0;

      // RUN ripple from 00:59:59
      applyStimulus(0, 0, 0, 1);
      checkOutput("run_ripple", 32'(strobes()), 32'b101010);
      applyStimulus(0, 0, 0, 0);
      checkOutput("run_chain", 32'(hour) * 10000 + 32'(min) * 100 + 32'(sec), 32'd10000);

      presetSec = 6'd0; presetMin = 6'd0; presetHour = 6'd0; presetEn = 1'b1;
      applyStimulus(0, 0, 0, 0);
      presetEn = 1'b0;

      // SET_HOUR, three up steps interleaved with ticks
      applyStimulus(1, 0, 0, 0);
      checkOutput("mode_edge_cycle_state", 32'(state), 32'd0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("set_hour_state", 32'(state), 32'd1);
      checkOutput("set_hour_blink", 32'(blink), 32'd1);
      hourBase  = hourUpCount;
      otherBase = otherCount;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 0, 0);
         checkOutput("hour_up_edge_cycle", 32'(strobes()), 32'd0);
         applyStimulus(0, 0, 0, 0);
         checkOutput("hour_up_next_cycle", 32'(strobes()), 32'b000010);
         applyStimulus(0, 0, 0, 1);
         checkOutput("tick_in_set", 32'(strobes()), 32'd0);
      end
      applyStimulus(0, 0, 0, 0);
      checkOutput("hour_up_pulses", 32'(hourUpCount - hourBase), 32'd3);
      checkOutput("no_sec_min_strobes", 32'(otherCount - otherBase), 32'd0);
      checkOutput("hour_after_ups", 32'(hour), 32'd3);

      // down from hour 0 wraps to 23
      presetHour = 6'd0; presetEn = 1'b1;
      applyStimulus(0, 0, 0, 0);
      presetEn = 1'b0;
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("hour_down_strobe", 32'(strobes()), 32'b000001);
      applyStimulus(0, 0, 0, 0);
      checkOutput("hour_wrap_23", 32'(hour), 32'd23);

      // SET_MIN simultaneous events
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("set_min_state", 32'(state), 32'd2);
      applyStimulus(0, 1, 1, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("up_down_dropped", 32'(strobes()), 32'd0);
      applyStimulus(1, 1, 0, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("mode_wins_state", 32'(state), 32'd3);
      checkOutput("mode_wins_strobes", 32'(strobes()), 32'd0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("min_unchanged", 32'(min), 32'd0);

      // SET_SEC timeout after 30 ticks
      prevBlink = blink;
      toggles   = 0;
      expStrobe = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         applyStimulus(0, 0, 0, 1);
         if (strobes() != 6'd0) expStrobe = 1'b1;
         applyStimulus(0, 0, 0, 0);
         if (k < 30 && blink != prevBlink) toggles++;
         prevBlink = blink;
         if (k == 29) begin
            checkOutput("before_timeout_state", 32'(state), 32'd3);
            checkOutput("before_timeout_blink", 32'(blink), 32'd0);
         end
      end
      checkOutput("tick_strobes_in_set_sec", 32'(expStrobe), 32'd0);
      checkOutput("timeout_state", 32'(state), 32'd0);
      checkOutput("timeout_blink", 32'(blink), 32'd1);
      checkOutput("blink_toggles", 32'(toggles), 32'd29);

      // async reset with a strobe in flight
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0);
      @(posedge clk);
      #2;
      checkOutput("strobe_before_reset", 32'(strobes()), 32'b000010);
      rstn = 1'b0;
      #1;
      checkOutput("reset_mid_set_state", 32'(state), 32'd0);
      checkOutput("reset_mid_set_strobes", 32'(strobes()), 32'd0);
      upBtn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;

      // held up button in SET_MIN
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("hold_set_min_state", 32'(state), 32'd2);
      for (int k = 0; k <= 20; k++) begin
         applyStimulus(0, (k < 20), 0, 0);
`ifdef AUTOREPEAT_EN
         expStrobe = (k == 1) || (k >= 8 && k % 4 == 0);
`else
         expStrobe = (k == 1);
`endif
         checkOutput($sformatf("hold_min_up_c%0d", k), 32'(minUp), 32'(expStrobe));
      end
      applyStimulus(0, 0, 0, 0);
`ifdef AUTOREPEAT_EN
      checkOutput("hold_min_value", 32'(min), 32'd5);
`else
      checkOutput("hold_min_value", 32'(min), 32'd1);
`endif

      for (int k = 0; k < 10; k++) applyStimulus(0, 1, 0, 0);
      rstn = 1'b0;
      #1;
      checkOutput("reset_mid_hold_state", 32'(state), 32'd0);
      checkOutput("reset_mid_hold_strobes", 32'(strobes()), 32'd0);
      upBtn = 1'b0;
      applyStimulus(0, 0, 0, 0);
      rstn = 1'b1;
      applyStimulus(0, 0, 0, 0);
      checkOutput("no_clear_pairs", 32'(pairCount), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
